// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchronizer, debounce, edge pulse,
// sticky flag and wrapping event counter.
module multi_edge_detector #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                    CLK_50M,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [NUM_CH-1:0]       clear,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    any_pulse
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync;
  logic [NUM_CH-1:0] level_d;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] pulse_nxt;
  logic [DEB_W-1:0]  deb_cnt [NUM_CH];
  logic [CNT_W-1:0]  evt_cnt [NUM_CH];

  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Counter runs only while the synchronized input disagrees with the accepted level.
  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      level   <= '0;
      level_d <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) deb_cnt[c] <= '0;
    end else begin
      level_d <= level;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (sync[c] == level[c]) begin
          deb_cnt[c] <= '0;
        end else if (deb_cnt[c] == DEB_LAST) begin
          level[c]   <= sync[c];
          deb_cnt[c] <= '0;
        end else begin
          deb_cnt[c] <= deb_cnt[c] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise      = level & ~level_d;
    fall      = ~level & level_d;
    pulse_nxt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pulse_nxt[c] = (rise[c] & mode[2*c]) | (fall[c] & mode[2*c+1]);
    end
  end

  // A pulse in the same cycle as clear keeps the flag set.
  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      pulse <= '0;
      flag  <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) evt_cnt[c] <= '0;
    end else begin
      pulse <= pulse_nxt;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (pulse[c]) begin
          flag[c] <= 1'b1;
        end else if (clear[c]) begin
          flag[c] <= 1'b0;
        end
        evt_cnt[c] <= evt_cnt[c] + CNT_W'(pulse[c]);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      count[c*CNT_W +: CNT_W] = evt_cnt[c];
    end
  end

  assign any_pulse = |pulse;

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a level change, legal range 1..65535.
REQ-004 Parameter CNT_W, default 8: per-channel event counter width, legal range 1..16.
REQ-005 CLK_50M  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 sig_in  input  NUM_CH  asynchronous raw inputs, one bit per channel.
REQ-008 mode  input  2*NUM_CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 clear  input  NUM_CH  synchronous per-channel clear of the sticky flag.
REQ-010 level  output  NUM_CH  debounced level per channel.
REQ-011 pulse  output  NUM_CH  registered one-cycle event pulse per channel.
REQ-012 flag  output  NUM_CH  sticky event flag per channel.
REQ-013 count  output  NUM_CH*CNT_W  per-channel event count; channel c occupies [c*CNT_W +: CNT_W].
REQ-014 any_pulse  output  1  OR of all pulse bits, purely combinational from the pulse registers.

Function
REQ-015 Each sig_in bit SHALL pass through SYNC_STAGES flops before any other use; the final stage output is sync[c].
REQ-016 Debounce per channel: if sync[c]==level[c], the counter SHALL be 0; otherwise it SHALL increment each cycle.
REQ-017 When sync[c]!=level[c] and the counter equals DEBOUNCE_CYCLES-1, level[c] SHALL take sync[c] and the counter SHALL return to 0.
REQ-018 A mismatch shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave level[c] unchanged and SHALL produce no pulse.
REQ-019 Edge detection SHALL compare level[c] with a one-cycle-delayed copy; rise = level & ~level_d, fall = ~level & level_d.
REQ-020 pulse[c] SHALL be registered and SHALL equal (rise & mode bit 0) | (fall & mode bit 1), using mode sampled in the same cycle as the edge.
REQ-021 pulse[c] SHALL be high for exactly one cycle per accepted level change, glitch-free.
REQ-022 Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges from the first edge after sig_in changes to pulse high.
REQ-023 Mode 00 SHALL suppress pulse, flag and count updates; level SHALL still track.
REQ-024 flag[c] SHALL set on the cycle after pulse[c] is high and clear on the cycle after clear[c] is high; if set and clear coincide, set SHALL win.
REQ-025 count[c] SHALL increment by 1 on the cycle after each pulse[c] and SHALL wrap from 2^CNT_W-1 to 0; clear SHALL NOT affect count.
REQ-026 Channels SHALL be fully independent; simultaneous events on any subset SHALL each be reported in the same cycle.

Reset
REQ-027 reset low SHALL immediately clear all synchronizer flops, debounce counters, level, level_d, pulse, flag and count to 0, regardless of CLK_50M.
REQ-028 Reset asserted mid-debounce or mid-pulse SHALL discard the in-flight event; no pulse SHALL appear after release unless the input again qualifies.
REQ-029 After release, a channel whose input is held high SHALL be treated as a rising edge and SHALL pulse after REQ-022 latency if its mode enables rising.

Verification (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-030 sig_in[0] 0->1, held, mode[1:0]=01 -> pulse[0] high exactly 1 cycle, 7 edges later; level[0]=1; flag[0]=1; count[0]=1.
REQ-031 sig_in[1] high for 3 cycles then low, mode=11 -> no pulse, level[1] stays 0, count[1]=0.
REQ-032 sig_in[2] 0->1->0, each held 10 cycles, mode=10 -> a single pulse on the falling transition only; count[2]=1.
REQ-033 clear[0] and pulse[0] high in the same cycle -> flag[0] remains 1; clear[0] alone next cycle -> flag[0]=0; count[0] unchanged.
REQ-034 256 qualified edges on channel 3, mode=11 -> count[3] wraps to 0; any_pulse high on every pulse cycle.
REQ-035 reset asserted 2 cycles into a debounce window, then released with the input held high -> all outputs 0 immediately; one rising pulse 7 edges after release.
